// File: rtl/menu_selector.sv
// Menu renderer/selector for the 96x64 RGB565 OLED: stacked item boxes, button-driven cursor, confirmed choice latch.
// Optional build macro MENU_WRAP_EN: cursor wraps at both ends instead of saturating.
module menu_selector #(
  parameter int          N_ITEMS  = 4,
  parameter int          CHOICE_W = 3,
  parameter int          ROW0     = 4,
  parameter int          ITEM_H   = 12,
  parameter int          X0       = 8,
  parameter int          X1       = 87,
  parameter logic [15:0] SEL_COL  = 16'h07E0,
  parameter logic [15:0] CONF_COL = 16'hF800,
  parameter logic [15:0] BOX_COL  = 16'hFFFF
) (
  input  logic                clock,
  input  logic                resetn,
  input  logic                showmenu,
  input  logic                btn_up,
  input  logic                btn_down,
  input  logic                btn_centre,
  input  logic [12:0]         pixel_index,
  output logic [15:0]         oled_data,
  output logic [CHOICE_W-1:0] cursor,
  output logic [CHOICE_W-1:0] choice,
  output logic                choice_valid
);

  typedef enum logic [1:0] {HIDDEN, BROWSE, CONFIRMED} state_t;

  localparam logic [CHOICE_W-1:0] LAST = CHOICE_W'(N_ITEMS - 1);

  state_t              r_state, w_state_nxt;
  logic                r_up_q, r_dn_q, r_ce_q;
  logic                w_up_ev, w_dn_ev, w_ce_ev;
  logic                w_session_start, w_browse_act, w_confirm, w_draw_sel, w_draw_conf;
  logic [CHOICE_W-1:0] w_cursor_nxt;

  // History resets high so a button held through reset does not fire.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) {r_up_q, r_dn_q, r_ce_q} <= 3'b111;
    else         {r_up_q, r_dn_q, r_ce_q} <= {btn_up, btn_down, btn_centre};
  end

  assign w_up_ev = btn_up     & ~r_up_q;
  assign w_dn_ev = btn_down   & ~r_dn_q;
  assign w_ce_ev = btn_centre & ~r_ce_q;

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) r_state <= HIDDEN;
    else         r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      HIDDEN:    if (showmenu) w_state_nxt = BROWSE;
      BROWSE:    if (!showmenu) w_state_nxt = HIDDEN;
                 else if (w_ce_ev) w_state_nxt = CONFIRMED;
      CONFIRMED: if (!showmenu) w_state_nxt = HIDDEN;
      default:   w_state_nxt = HIDDEN;
    endcase
  end

  always_comb begin
    w_session_start = (r_state == HIDDEN) && showmenu;
    w_browse_act    = (r_state == BROWSE) && showmenu;
    w_confirm       = w_browse_act && w_ce_ev;
    w_draw_sel      = (r_state != HIDDEN);
    w_draw_conf     = (r_state == CONFIRMED);
  end

  // Centre wins over movement; simultaneous up+down cancels.
  always_comb begin
    w_cursor_nxt = cursor;
    if (w_browse_act && !w_ce_ev) begin
      if (w_up_ev && !w_dn_ev) begin
`ifdef MENU_WRAP_EN
        w_cursor_nxt = (cursor == '0) ? LAST : cursor - 1'b1;
`else
        w_cursor_nxt = (cursor == '0) ? '0 : cursor - 1'b1;
`endif
      end else if (w_dn_ev && !w_up_ev) begin
`ifdef MENU_WRAP_EN
        w_cursor_nxt = (cursor == LAST) ? '0 : cursor + 1'b1;
`else
        w_cursor_nxt = (cursor == LAST) ? LAST : cursor + 1'b1;
`endif
      end
    end
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      cursor       <= '0;
      choice       <= '0;
      choice_valid <= 1'b0;
    end else begin
      cursor <= w_cursor_nxt;
      if (w_confirm) begin
        choice       <= cursor;
        choice_valid <= 1'b1;
      end else if (w_session_start) begin
        choice_valid <= 1'b0;
      end
    end
  end

  // Stage 1: index/96 == (index>>5)/3, done as restoring division by 3.
  logic [7:0] w_q, w_quo;
  logic [2:0] w_rem;
  logic [6:0] r_x;
  logic [7:0] r_y;
  logic       r_oob;

  assign w_q = pixel_index[12:5];

  always_comb begin
    w_rem = '0;
    w_quo = '0;
    for (int b = 7; b >= 0; b--) begin
      w_rem = {w_rem[1:0], w_q[b]};
      if (w_rem >= 3'd3) begin
        w_rem    = w_rem - 3'd3;
        w_quo[b] = 1'b1;
      end
    end
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      r_x   <= '0;
      r_y   <= '0;
      r_oob <= 1'b0;
    end else begin
      r_x   <= {w_rem[1:0], pixel_index[4:0]};
      r_y   <= w_quo;
      r_oob <= (pixel_index >= 13'd6144);
    end
  end

  // Stage 2: items never overlap, so at most one iteration hits.
  int          w_xi, w_yi;
  logic [15:0] w_col;

  assign w_xi = int'(r_x);
  assign w_yi = int'(r_y);

  always_comb begin
    w_col = '0;
    for (int i = 0; i < N_ITEMS; i++) begin
      if (w_yi >= ROW0 + i*ITEM_H && w_yi <= ROW0 + i*ITEM_H + ITEM_H - 2 &&
          w_xi >= X0 && w_xi <= X1) begin
        if (w_draw_conf && i == int'(choice))
          w_col = CONF_COL;
        else if (w_draw_sel && i == int'(cursor))
          w_col = SEL_COL;
        else if (w_yi == ROW0 + i*ITEM_H || w_yi == ROW0 + i*ITEM_H + ITEM_H - 2 ||
                 w_xi == X0 || w_xi == X1)
          w_col = BOX_COL;
      end
    end
    if (r_oob || r_state == HIDDEN) w_col = '0;
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) oled_data <= '0;
    else         oled_data <= w_col;
  end

endmodule
